// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter: opcodes, FSM states and the NAND primitive.
package logic_unit_arbiter_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_NOT  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic nand2(input logic x, input logic y);
      return ~(x & y);
   endfunction

endpackage

// File: rtl/nand_logic_unit.sv
// Combinational bitwise AND/OR/NOT/NAND unit built only from 2-input NAND gates,
// including the opcode select mux.
module nand_logic_unit
   import logic_unit_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic ns0;
   logic ns1;

   assign ns0 = nand2(op[0], op[0]);
   assign ns1 = nand2(op[1], op[1]);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic n_ab;
      logic and_y;
      logic na;
      logic nb;
      logic or_y;
      logic lo;
      logic hi;

      assign n_ab  = nand2(a[i], b[i]);
      assign and_y = nand2(n_ab, n_ab);
      assign na    = nand2(a[i], a[i]);
      assign nb    = nand2(b[i], b[i]);
      assign or_y  = nand2(na, nb);
      // Three NAND 2:1 muxes: op[0] picks within {AND,OR} and {NOT,NAND}, op[1] between them.
      assign lo    = nand2(nand2(and_y, ns0), nand2(or_y, op[0]));
      assign hi    = nand2(nand2(na, ns0), nand2(n_ab, op[0]));
      assign y[i]  = nand2(nand2(lo, ns1), nand2(hi, op[1]));
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin scheduler time-sharing one NAND logic unit among N_REQ requesters,
// returning tagged registered results on a single backpressured response channel.
module logic_unit_arbiter
   import logic_unit_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ID_W  = 3,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [2*N_REQ-1:0]     req_op,
   input  logic [WIDTH*N_REQ-1:0] req_a,
   input  logic [WIDTH*N_REQ-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   busy,
   output logic [CNT_W-1:0]       ops_done
);

   state_t           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [ID_W-1:0]  id_q;
   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] ops_done_q;

   logic             win_found;
   int unsigned      win_idx;
   int unsigned      idx;
   logic             grant;
   logic             rsp_hs;
   logic [WIDTH-1:0] unit_y;

   // Search from rr_ptr upward with wrap; idx never reaches N_REQ, so unused IDs are never granted.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 0;
      idx       = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(rr_ptr_q) + k) % N_REQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   assign grant  = (state_q == IDLE) && win_found && !rst;
   assign rsp_hs = (state_q == RESP) && rsp_ready;

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (win_found) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   nand_logic_unit #(
      .WIDTH(WIDTH)
   ) u_unit (
      .op(op_q),
      .a (a_q),
      .b (b_q),
      .y (unit_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         op_q       <= OP_AND;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= '0;
         data_q     <= '0;
         ops_done_q <= '0;
      end else begin
         if (grant) begin
            op_q <= req_op[2*win_idx +: 2];
            a_q  <= req_a[WIDTH*win_idx +: WIDTH];
            b_q  <= req_b[WIDTH*win_idx +: WIDTH];
            id_q <= ID_W'(win_idx);
         end
         if (state_q == EXEC) begin
            data_q <= unit_y;
         end
         if (rsp_hs) begin
            rr_ptr_q <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
            if (ops_done_q != '1) begin
               ops_done_q <= ops_done_q + 1'b1;
            end
         end
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign busy      = (state_q != IDLE);
   assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed plus randomized bench for logic_unit_arbiter against a transaction-level reference.
module tb_logic_unit_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned W     = 8;
   localparam int unsigned ID_W  = 3;
   localparam int unsigned CNT_W = 16;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [2*N-1:0]   req_op;
   logic [W*N-1:0]   req_a;
   logic [W*N-1:0]   req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [ID_W-1:0]  rsp_id;
   logic [W-1:0]     rsp_data;
   logic             busy;
   logic [CNT_W-1:0] ops_done;

   logic [1:0]   op_arr [N];
   logic [W-1:0] a_arr  [N];
   logic [W-1:0] b_arr  [N];

   int checks   = 0;
   int failures = 0;
   int m_ptr    = 0;
   int m_cnt    = 0;

   logic_unit_arbiter #(
      .N_REQ(N),
      .WIDTH(W),
      .ID_W (ID_W),
      .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_op   (req_op),
      .req_a    (req_a),
      .req_b    (req_b),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id   (rsp_id),
      .rsp_data (rsp_data),
      .busy     (busy),
      .ops_done (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_op = '0;
      req_a  = '0;
      req_b  = '0;
      for (int i = 0; i < N; i++) begin
         req_op[2*i +: 2] = op_arr[i];
         req_a[W*i +: W]  = a_arr[i];
         req_b[W*i +: W]  = b_arr[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (op)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return ~a;
         default: return ~(a & b);
      endcase
   endfunction

   function automatic int pick(input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called at a negedge with the DUT idle; runs one full transaction with `stall` cycles of
   // response backpressure, disturbing requester inputs after the grant.
   task automatic do_op(input logic [N-1:0] v, input int stall);
      int           win;
      logic [W-1:0] exp_d;
      req_valid = v;
      #1;
      win = pick(v);
      chk("idle_busy", 32'(busy), 32'(0));
      if (win < 0) begin
         chk("no_grant", 32'(req_ready), 32'(0));
         step();
         chk("stay_idle", 32'(busy), 32'(0));
         return;
      end
      chk("grant", 32'(req_ready), 32'(1) << win);
      exp_d = ref_op(op_arr[win], a_arr[win], b_arr[win]);
      step();
      chk("exec_busy", 32'(busy), 32'(1));
      chk("exec_ready", 32'(req_ready), 32'(0));
      chk("exec_rsp_valid", 32'(rsp_valid), 32'(0));
      req_valid   = v & N'($urandom);
      a_arr[win]  = ~a_arr[win];
      b_arr[win]  = W'($urandom);
      op_arr[win] = op_arr[win] + 2'd1;
      step();
      for (int s = 0; s <= stall; s++) begin
         chk("rsp_valid", 32'(rsp_valid), 32'(1));
         chk("rsp_id", 32'(rsp_id), 32'(win));
         chk("rsp_data", 32'(rsp_data), 32'(exp_d));
         chk("resp_ready", 32'(req_ready), 32'(0));
         chk("ops_hold", 32'(ops_done), 32'(m_cnt));
         rsp_ready = (s == stall);
         step();
      end
      m_cnt = (m_cnt == (1 << CNT_W) - 1) ? m_cnt : m_cnt + 1;
      m_ptr = (win + 1) % N;
      chk("after_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("after_busy", 32'(busy), 32'(0));
      chk("ops_done", 32'(ops_done), 32'(m_cnt));
   endtask

   initial begin
      int win;
      for (int i = 0; i < N; i++) begin
         op_arr[i] = 2'b00;
         a_arr[i]  = '0;
         b_arr[i]  = '0;
      end
      rst       = 1'b1;
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_ready", 32'(req_ready), 32'(0));
         chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
         chk("rst_ops_done", 32'(ops_done), 32'(0));
         chk("rst_busy", 32'(busy), 32'(0));
      end
      rst       = 1'b0;
      req_valid = '0;

      // Single AND on requester 1.
      op_arr[1] = 2'b00;
      a_arr[1]  = 8'hF0;
      b_arr[1]  = 8'h3C;
      do_op(4'b0010, 0);

      // Every opcode on a=A5 b=0F.
      for (int o = 0; o < 4; o++) begin
         op_arr[2] = 2'(o);
         a_arr[2]  = 8'hA5;
         b_arr[2]  = 8'h0F;
         do_op(4'b0100, 0);
      end

      // Fresh reset, then all requesters valid: strict rotation with wrap.
      rst = 1'b1;
      step();
      rst   = 1'b0;
      m_ptr = 0;
      m_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < N; i++) begin
            op_arr[i] = 2'($urandom);
            a_arr[i]  = W'($urandom);
            b_arr[i]  = W'($urandom);
         end
         do_op(4'b1111, 0);
      end

      // Long backpressure.
      do_op(4'b1011, 10);

      // Reset while stalled in RESP.
      req_valid = 4'b1111;
      #1;
      win = pick(4'b1111);
      chk("rr_grant", 32'(req_ready), 32'(1) << win);
      step();
      rsp_ready = 1'b0;
      step();
      chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'(1));
      rst = 1'b1;
      step();
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("midrst_ops_done", 32'(ops_done), 32'(0));
      chk("midrst_busy", 32'(busy), 32'(0));
      chk("midrst_rsp_id", 32'(rsp_id), 32'(0));
      chk("midrst_rsp_data", 32'(rsp_data), 32'(0));
      chk("midrst_ready", 32'(req_ready), 32'(0));
      rst       = 1'b0;
      rsp_ready = 1'b1;
      m_ptr     = 0;
      m_cnt     = 0;
      do_op(4'b1111, 0);

      // Randomized traffic.
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < N; i++) begin
            op_arr[i] = 2'($urandom);
            a_arr[i]  = W'($urandom);
            b_arr[i]  = W'($urandom);
         end
         do_op(N'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin scheduler that time-shares one NAND-built bitwise logic unit (AND/OR/NOT/NAND) among `N_REQ` requesters. Each requester presents an opcode and two operands with a valid/ready handshake. The arbiter grants one request at a time, sequences it through the shared unit, and returns a tagged, registered result on a single response channel with backpressure. It sits between the gate-level logic datapath and any blocks that need logic operations but cannot each own a copy.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `WIDTH`, 8: operand/result width in bits; all ops are bitwise
- `ID_W`, 3: requester-ID width; must satisfy 2^ID_W >= N_REQ
- `CNT_W`, 16: width of completed-operation counter
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in N_REQ: per-requester request valid
- `req_ready` out N_REQ: per-requester accept; at most one bit set
- `req_op` in 2*N_REQ: opcode, requester i at bits [2i+1:2i]
- `req_a` in WIDTH*N_REQ: operand A, requester i at [WIDTH*i +: WIDTH]
- `req_b` in WIDTH*N_REQ: operand B, same packing; ignored for NOT
- `rsp_valid` out 1: result valid
- `rsp_ready` in 1: consumer accepts result
- `rsp_id` out ID_W: index of the requester that owns the result
- `rsp_data` out WIDTH: result
- `busy` out 1: high whenever state != IDLE
- `ops_done` out CNT_W: count of completed response handshakes

## Operation
- Opcodes: 00 AND (a&b), 01 OR (a|b), 10 NOT (~a), 11 NAND (~(a&b)).
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching from `rr_ptr` upward with wrap.
  - `req_ready[winner]` = 1 combinationally, so the handshake completes that cycle.
  - Latch op, a, b and ID of the winner; go to EXEC.
  - With no valid requests, stay in IDLE with all `req_ready` = 0.
- EXEC: drive latched op/a/b into the logic unit, register its output into `rsp_data`, go to RESP. All `req_ready` = 0.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_id`/`rsp_data` hold stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready`:
    - `rr_ptr` <= (rsp_id + 1) mod N_REQ.
    - `ops_done` increments, saturating at all-ones.
    - Go to IDLE.
  - All `req_ready` = 0 in RESP.
- Requesters may drop `req_valid` before being granted; nothing is latched for a dropped request.
- `rr_ptr` wrap: after servicing ID N_REQ-1, the pointer becomes 0.
- Out-of-range IDs (>= N_REQ, when N_REQ is not a power of 2) are never granted.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `ops_done` 0, `busy` 0.
  - `req_ready` is forced to 0 while `rst` is high.
- Latency: grant at cycle T, `rsp_valid` rises at T+2 (registered), and the response can complete at T+2.
- Peak throughput: one operation per 3 cycles. IDLE is re-entered for at least one cycle per op, so there is no back-to-back grant.
- Simultaneous valid on all requesters: grants go strictly in rotation, ptr, ptr+1, and so on.
- `rsp_ready` held low: the FSM stalls in RESP indefinitely, and no new grants are issued.
- Reset mid-EXEC/RESP: the in-flight result is discarded, no handshake is counted, and all outputs return to reset values on the next edge.

## Structure
- Shared package/header holds:
  - opcode constants `OP_AND`=2'b00, `OP_OR`=2'b01, `OP_NOT`=2'b10, `OP_NAND`=2'b11
  - FSM state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2
- One sub-module, `nand_logic_unit`:
  - inputs `op` [1:0], `a`, `b` [WIDTH-1:0]; output `y` [WIDTH-1:0]
  - purely combinational, built bitwise from 2-input NAND primitives only
  - instantiated once in the arbiter
- The arbiter holds the FSM, the round-robin priority encoder, the operand/ID latches, the result register and the counter.

## Test plan
- Reset: assert `rst` 2 cycles with `req_valid`=4'b1111 -> `req_ready`=0, `rsp_valid`=0, `ops_done`=0, `busy`=0.
- Single op: req1 op=00 a=8'hF0 b=8'h3C, `rsp_ready`=1 -> `req_ready`=4'b0010 for 1 cycle; 2 cycles later `rsp_valid`=1, `rsp_id`=1, `rsp_data`=8'h30; `ops_done`=1.
- All opcodes: a=8'hA5 b=8'h0F -> AND 8'h05, OR 8'hAF, NOT 8'h5A, NAND 8'hFA.
- Fairness: `req_valid`=4'b1111 held for 4 ops -> `rsp_id` sequence 0,1,2,3, then wraps to 0; each grant spaced exactly 3 cycles apart.
- Backpressure: `rsp_ready`=0 for 10 cycles in RESP -> `rsp_data`/`rsp_id` stable, `req_ready`=0 throughout, `ops_done` unchanged until the handshake.
- Reset in RESP with `rsp_ready`=0 -> next cycle `rsp_valid`=0, `ops_done` not incremented, `rr_ptr` back to 0 (next grant goes to requester 0).
